// File: rtl/pts_output_ctrl.sv
// Sequencer for the 32x16 parallel-to-serial output shifter at the FFT result boundary.
// It loads one frame, then shifts it out one sample per downstream handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for fft_done; no outputs asserted
// LOAD   | load_enable high for one cycle; remaining counter armed
// STREAM | one strobe per sample, paced by out_valid/out_ready
module pts_output_ctrl #(
    parameter int NUM_SAMPLES = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       fft_done,
    input  logic       out_ready,
    input  logic       err_clr,
    output logic       load_enable,
    output logic       out_strobe,
    output logic       out_valid,
    output logic       out_last,
    output logic [4:0] sample_idx,
    output logic       busy,
    output logic       overrun_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [4:0]       sample_idx_q, sample_idx_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             strobe;

    assign accept = out_valid_q & out_ready;
    // One-deep presentation: refill in the same cycle the current sample is taken.
    assign strobe = (state_q == STREAM) && (remaining_q != '0) && (!out_valid_q || out_ready);

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        sample_idx_d = sample_idx_q;

        case (state_q)
            IDLE: begin
                if (fft_done) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                remaining_d = CNT_W'(NUM_SAMPLES);
                state_d     = STREAM;
            end
            STREAM: begin
                if (strobe) begin
                    remaining_d  = remaining_q - CNT_W'(1);
                    out_valid_d  = 1'b1;
                    sample_idx_d = 5'(CNT_W'(NUM_SAMPLES) - remaining_q);
                    out_last_d   = (remaining_q == CNT_W'(1));
                end else if (accept) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (accept && out_last_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A set in the same cycle as a clear must win so no overrun is lost.
    always_comb begin
        overrun_d = overrun_q;
        if (fft_done && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            sample_idx_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            sample_idx_q <= sample_idx_d;
            overrun_q    <= overrun_d;
        end
    end

    assign load_enable = (state_q == LOAD);
    assign out_strobe  = strobe;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign sample_idx  = sample_idx_q;
    assign busy        = (state_q != IDLE);
    assign overrun_err = overrun_q;

endmodule

// File: doc/pts_output_ctrl.md
Name: pts_output_ctrl

Overview:
Sequencer for the 32x16 parallel-to-serial output shift register at the FFT result boundary. When the FFT core reports a finished frame, the block issues one load pulse to the shifter. It then issues one shift strobe per sample, paced by a downstream valid/ready handshake, so the 32 bins leave in index order (bin 0 first) without loss or duplication. It also flags frames that arrive while a previous frame is still draining.

Parameters:
NUM_SAMPLES, 32, samples per frame; equals the shifter depth.
CNT_W, 6, width of the remaining-sample counter; must hold NUM_SAMPLES (clog2(NUM_SAMPLES)+1).

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  reset; synchronous, active-low
fft_done  input  1  single-cycle pulse: a full frame is on the shifter parallel input this cycle
out_ready  input  1  downstream accepts the sample on the shifter serial output this cycle
err_clr  input  1  clears overrun_err
load_enable  output  1  to shifter; load parallel frame
out_strobe  output  1  to shifter; shift the next sample to its serial output
out_valid  output  1  shifter serial output holds an unaccepted sample
out_last  output  1  qualifies out_valid; the sample is the final one of the frame
sample_idx  output  5  bin index of the presented sample; meaningful only while out_valid=1
busy  output  1  state != IDLE
overrun_err  output  1  sticky; fft_done was seen while busy

Behaviour:
- Clock and reset: one clock domain, clk. Reset n_rst is synchronous and active-low. When n_rst=0 at a rising edge:
  - state <= IDLE; remaining <= 0.
  - out_valid, out_last, sample_idx, overrun_err <= 0.
  - load_enable, out_strobe and busy are therefore 0 in the following cycle.
  - Reset mid-frame abandons the frame. The shifter shares n_rst and clears with it.
- States: IDLE, LOAD, STREAM.
- IDLE:
  - fft_done=1 -> LOAD.
  - No outputs are asserted.
- LOAD:
  - load_enable=1 for exactly this cycle (Moore output).
  - remaining <= NUM_SAMPLES; next state STREAM.
- STREAM:
  - accept = out_valid & out_ready.
  - out_strobe = (remaining != 0) & (!out_valid | out_ready). This is combinational from registers and out_ready; it gives one-deep presentation with zero-bubble back-to-back transfer.
  - On out_strobe:
    - remaining <= remaining - 1.
    - out_valid <= 1.
    - sample_idx <= NUM_SAMPLES - remaining.
    - out_last <= (remaining == 1).
  - On accept without out_strobe: out_valid <= 0, out_last <= 0.
  - On accept with out_last=1 (remaining is necessarily 0): next state IDLE; out_valid and out_last clear.
  - out_valid/out_last hold while out_ready=0. There is no timeout.
- Mutual exclusion: load_enable and out_strobe are never high in the same cycle. out_strobe is never high outside STREAM.
- Latency with out_ready held at 1:
  - fft_done in cycle 0; load_enable in cycle 1.
  - out_strobe in cycles 2..33; out_valid in cycles 3..34.
  - out_last in cycle 34; busy deasserts in cycle 35.
  - A new fft_done is accepted from cycle 35.
- Overrun:
  - fft_done while state != IDLE sets overrun_err <= 1. The pulse is otherwise ignored; the current frame continues unaffected. This includes the final accept cycle.
  - err_clr=1 clears overrun_err. If err_clr and an overrun event occur in the same cycle, set wins.
- out_ready is ignored while out_valid=0, except in the strobe equation.

Test Plan:
- Reset then idle: n_rst=0 for 2 cycles, then fft_done=0 for 10 cycles -> all outputs 0, no strobes.
- Full-rate frame: fft_done pulse in cycle 0, out_ready=1 throughout, shifter preloaded with bin k = 16'h0100+k:
  - load_enable only in cycle 1; 32 strobes in cycles 2..33.
  - Serial data 0x0100..0x011F in order, with sample_idx 0..31 matching.
  - out_last only in cycle 34; busy=0 in cycle 35.
- Backpressure: out_ready alternating 1/0 and held 0 for 5 cycles around sample 10:
  - No strobe while out_valid=1 and out_ready=0.
  - Exactly 32 accepts, no repeats or skips, data still 0x0100..0x011F.
- Overrun: second fft_done in cycle 20 of a frame:
  - overrun_err=1 from cycle 21; the frame still completes all 32 samples.
  - No second load_enable; err_clr=1 in a later cycle -> overrun_err=0 the next cycle.
- Reset mid-frame: n_rst=0 at sample 12 -> next cycle state IDLE, out_valid=0, remaining=0. A following fft_done produces a clean 32-sample frame starting at idx 0.
- Back-to-back frames: second fft_done in cycle 35 after a full-rate frame -> accepted with no overrun; load_enable in cycle 36.
